structural_mux2: RTL and testbench
==================================

Name: structural_mux2

Overview:
- WIDTH-bit 2:1 multiplexer built structurally from gate-level primitives: inverter, 2-input AND and 2-input OR cells, one slice per bit.
- Primary output y is purely combinational and must follow d0/d1/s with zero clock latency.
- A registered copy y_q, plus a registered select s_q, is provided for downstream synchronous consumers.
- Used as a datapath leaf cell and as a teaching example of structural composition.

Parameters:
- WIDTH, 4, data width of d0, d1, y, y_q.

Ports:
- clk  input  1  rising-edge clock; used only by the registered outputs.
- reset  input  1  asynchronous, active-high reset; clears the registered outputs only.
- d0  input  WIDTH  data selected when s=0.
- d1  input  WIDTH  data selected when s=1.
- s  input  1  select.
- y  output  WIDTH  combinational mux output.
- y_q  output  WIDTH  y registered on the rising edge of clk.
- s_q  output  1  s registered on the rising edge of clk.

Behaviour:
- Combinational path, per bit i: y[i] = (d0[i] AND NOT s) OR (d1[i] AND s).
  - Implement with explicit inverter/AND/OR cell instances in a generate loop. No behavioural ?: operator on the y path.
  - The single inverted select net (sb) is shared by all slices.
- y does not depend on clk or reset.
  - y is valid during reset.
  - y settles within the same simulation time step as any change on d0, d1 or s. No cycle latency.
- s = 0 -> y = d0; s = 1 -> y = d1, on all WIDTH bits simultaneously.
- s = X or Z -> y bits where d0[i] == d1[i] resolve to that value. Other bits may be X. No further requirement.
- Registered path:
  - reset asserted (asynchronously, no clock needed) -> y_q = 0 and s_q = 0 immediately.
  - reset held -> y_q and s_q stay 0 regardless of clk.
  - reset deasserted -> on each rising clk edge, y_q <= y and s_q <= s. One-cycle latency relative to y.
  - reset asserted mid-operation -> registered outputs clear immediately; y continues to track its inputs.
- Simultaneous change of s and data in the same time step -> y reflects the new s with the new data. No glitch requirement at RTL level.
- No internal state other than y_q and s_q. No handshake.

Test Plan:
1. reset=1, d0=4'b1010, d1=4'b0101, s=0 -> y=1010 immediately; y_q=0000 and s_q=0 even with clk toggling.
2. reset=0, s toggled 0,1,0,1,0 at 5-time-unit intervals with d0=1010, d1=0101 -> y alternates 1010, 0101, 1010, 0101, 1010 at each change with zero delay.
3. Clock running, s=1, d1=0101 -> y_q=0101 and s_q=1 one rising edge later. Then s=0 -> y_q=1010 after the next edge.
4. d0=d1=4'b1111 while s toggles -> y stays 1111 throughout.
5. Registered outputs holding 0101, assert reset between clock edges -> y_q=0000 and s_q=0 without a clock edge; y unaffected.
6. WIDTH=8, d0=8'hA5, d1=8'h5A, s=1 then 0 -> y=8'h5A then 8'hA5.

Source files
------------

// File: rtl/structural_mux2_if.sv
// structural_mux2_if -- data/select bundle for the structural 2:1 mux.
//   d0, d1 : WIDTH-bit data inputs (d0 selected when s=0, d1 when s=1)
//   s      : select
//   y      : combinational mux output
//   y_q    : y registered on rising clk
//   s_q    : s registered on rising clk
// master drives data/select and observes results; slave is the mux itself.
interface structural_mux2_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] d0;
    logic [WIDTH-1:0] d1;
    logic             s;
    logic [WIDTH-1:0] y;
    logic [WIDTH-1:0] y_q;
    logic             s_q;

    modport master (output d0, d1, s, input  y, y_q, s_q);
    modport slave  (input  d0, d1, s, output y, y_q, s_q);
endinterface

// File: rtl/structural_mux2.sv
// structural_mux2 -- WIDTH-bit 2:1 mux composed from inverter/AND2/OR2 cells,
// one slice per bit, plus registered copies of y and s.
//   clk   : rising-edge clock, registered outputs only
//   reset : asynchronous active-high, clears y_q/s_q only
//   bus   : structural_mux2_if.slave (d0, d1, s in; y, y_q, s_q out)
// y is purely combinational and ignores clk/reset.

module inv_cell (
    input  logic a,
    output logic y
);
    assign y = ~a;
endmodule

module and2_cell (
    input  logic a,
    input  logic b,
    output logic y
);
    assign y = a & b;
endmodule

module or2_cell (
    input  logic a,
    input  logic b,
    output logic y
);
    assign y = a | b;
endmodule

module structural_mux2 #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    structural_mux2_if.slave bus
);
    logic             sb;        // inverted select, shared by every slice
    logic [WIDTH-1:0] y_w;

    inv_cell u_inv (.a(bus.s), .y(sb));

    // Per bit: y = (d0 & sb) | (d1 & s) | (d0 & d1).
    // The d0&d1 consensus term is logically redundant but makes a bit
    // whose two data inputs agree resolve to that value even when s is
    // X/Z, and removes the select-switch hazard on such bits.
    genvar i;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_slice
            logic t0, t1, tc, t01;
            and2_cell u_and0 (.a(bus.d0[i]), .b(sb),        .y(t0));
            and2_cell u_and1 (.a(bus.d1[i]), .b(bus.s),     .y(t1));
            and2_cell u_andc (.a(bus.d0[i]), .b(bus.d1[i]), .y(tc));
            or2_cell  u_or0  (.a(t0),        .b(t1),        .y(t01));
            or2_cell  u_or1  (.a(t01),       .b(tc),        .y(y_w[i]));
        end
    endgenerate

    assign bus.y = y_w;

    logic [WIDTH-1:0] yreg_d, yreg_q;
    logic             sreg_d, sreg_q;

    assign yreg_d = y_w;
    assign sreg_d = bus.s;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            yreg_q <= '0;
            sreg_q <= 1'b0;
        end else begin
            yreg_q <= yreg_d;
            sreg_q <= sreg_d;
        end
    end

    assign bus.y_q = yreg_q;
    assign bus.s_q = sreg_q;
endmodule

// File: tb/tb_structural_mux2.sv
module tb_structural_mux2;
    logic clk   = 1'b0;
    logic reset = 1'b1;

    structural_mux2_if #(.WIDTH(4)) bus4 ();
    structural_mux2_if #(.WIDTH(8)) bus8 ();

    structural_mux2 #(.WIDTH(4)) dut4 (.clk(clk), .reset(reset), .bus(bus4));
    structural_mux2 #(.WIDTH(8)) dut8 (.clk(clk), .reset(reset), .bus(bus8));

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    logic [7:0] exp_q[$];

    // Expected value goes into the scoreboard when the stimulus is applied.
    task automatic push(input logic [7:0] v);
        exp_q.push_back(v);
    endtask

    // Pop the oldest expectation and compare it with what the DUT shows now.
    task automatic chk(input string tag, input logic [7:0] obs);
        logic [7:0] e;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $error("FAIL %s scoreboard empty, got=%h", tag, obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e) else begin
                bad++;
                $error("FAIL %s got=%h exp=%h", tag, obs, e);
            end
        end
    endtask

    initial begin
        bus4.d0 = 4'b1010; bus4.d1 = 4'b0101; bus4.s = 1'b0;
        bus8.d0 = 8'hA5;   bus8.d1 = 8'h5A;   bus8.s = 1'b0;

        // 1: reset held, y live, registered outputs cleared with clock running
        push(8'h0A); push(8'h00); push(8'h00);
        #1;
        chk("rst_y",   {4'h0, bus4.y});
        chk("rst_yq",  {4'h0, bus4.y_q});
        chk("rst_sq",  {7'h0, bus4.s_q});
        bus4.s = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        push(8'h00); push(8'h00); push(8'h05);
        chk("rsthold_yq", {4'h0, bus4.y_q});
        chk("rsthold_sq", {7'h0, bus4.s_q});
        chk("rsthold_y",  {4'h0, bus4.y});

        // 2: select toggling, zero-delay combinational response
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 5; k++) begin
            bus4.s = k[0];
            push(k[0] ? 8'h05 : 8'h0A);
            #1;
            chk("toggle_y", {4'h0, bus4.y});
            #4;
        end

        // 3: one-cycle latency on y_q / s_q
        @(negedge clk);
        bus4.s = 1'b1;
        push(8'h05);
        #1 chk("lat_y_now", {4'h0, bus4.y});
        @(posedge clk); #1;
        push(8'h05); push(8'h01);
        chk("lat_yq1", {4'h0, bus4.y_q});
        chk("lat_sq1", {7'h0, bus4.s_q});
        @(negedge clk);
        bus4.s = 1'b0;
        push(8'h05);
        #1 chk("lat_yq_hold", {4'h0, bus4.y_q});
        @(posedge clk); #1;
        push(8'h0A); push(8'h00);
        chk("lat_yq0", {4'h0, bus4.y_q});
        chk("lat_sq0", {7'h0, bus4.s_q});

        // 4: equal data, select irrelevant
        bus4.d0 = 4'hF; bus4.d1 = 4'hF;
        for (int k = 0; k < 4; k++) begin
            bus4.s = ~bus4.s;
            push(8'h0F);
            #1 chk("eq_y", {4'h0, bus4.y});
            #2;
        end

        // simultaneous data + select change
        bus4.d0 = 4'b0011; bus4.d1 = 4'b1100; bus4.s = 1'b1;
        push(8'h0C);
        #1 chk("simul_y", {4'h0, bus4.y});

        // 5: asynchronous reset between edges
        @(negedge clk);
        bus4.d0 = 4'b1010; bus4.d1 = 4'b0101; bus4.s = 1'b1;
        @(posedge clk); #1;
        push(8'h05);
        chk("pre_rst_yq", {4'h0, bus4.y_q});
        @(negedge clk); #2;
        reset = 1'b1;
        push(8'h00); push(8'h00); push(8'h05);
        #1;
        chk("async_yq", {4'h0, bus4.y_q});
        chk("async_sq", {7'h0, bus4.s_q});
        chk("async_y",  {4'h0, bus4.y});
        bus4.s = 1'b0;
        push(8'h0A);
        #1 chk("async_y_track", {4'h0, bus4.y});
        @(posedge clk); #1;
        push(8'h00);
        chk("async_yq_edge", {4'h0, bus4.y_q});

        // 6: WIDTH=8 instance
        @(negedge clk);
        reset = 1'b0;
        bus8.s = 1'b1;
        push(8'h5A);
        #1 chk("w8_y1", bus8.y);
        @(posedge clk); #1;
        push(8'h5A);
        chk("w8_yq1", bus8.y_q);
        @(negedge clk);
        bus8.s = 1'b0;
        push(8'hA5);
        #1 chk("w8_y0", bus8.y);
        @(posedge clk); #1;
        push(8'hA5);
        chk("w8_yq0", bus8.y_q);

        // random sweep on the 8-bit slice
        for (int k = 0; k < 16; k++) begin
            logic [7:0] a, b;
            logic       sel;
            @(negedge clk);
            a = 8'($urandom); b = 8'($urandom); sel = 1'($urandom);
            bus8.d0 = a; bus8.d1 = b; bus8.s = sel;
            push(sel ? b : a);
            #1 chk("rnd_y", bus8.y);
            @(posedge clk); #1;
            push(sel ? b : a);
            chk("rnd_yq", bus8.y_q);
        end

        total++;
        assert (exp_q.size() == 0) else begin
            bad++;
            $error("FAIL sb_drain left=%0d exp=0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
